virq_arbiter: RTL
=================

// Module: virq_arbiter
// PURPOSE
//  Shares the CPU's single vectored-interrupt request/acknowledge channel among N bus
//  peripherals (keyboard 060/274, timer, serial, ...), each with its own virq_req/virq_ack pair.
//  Selects one pending requester, presents its vector to the CPU, and routes the CPU's
//  acknowledge back to that requester only.
//  Sits between the peripheral virq ports and the CPU core's interrupt input.
// PARAMETERS
//  N        4         number of requesters (1..8); index 0 = highest fixed priority
//  VECTORS  {9'o274,9'o060,..}  N*9-bit packed vector table; slot i = VECTORS[i*9 +: 9]
//  RR       0         0 = fixed priority (lowest index wins); 1 = round-robin from rr_ptr
//  ACK_TMO  255       max cycles the ack is held waiting for req to drop (8-bit counter)
// PORTS
//  clk_bus      in   1    bus clock; all logic on posedge
//  bus_reset_n  in   1    synchronous, active-low reset
//  virq_req     in   N    level requests from peripherals
//  virq_ack     out  N    per-requester acknowledge, one-hot or zero
//  irq_mask     in   N    1 = requester i is ignored for new selection
//  cpu_ie       in   1    CPU currently accepts vectored interrupts
//  cpu_virq     out  1    interrupt request to CPU
//  cpu_vector   out  9    vector of the offered requester (valid while cpu_virq=1)
//  cpu_iack     in   1    CPU acknowledge; acted on at its rising edge
//  busy         out  1    state != IDLE
// BEHAVIOUR
//  - Reset (bus_reset_n=0 at posedge): state=IDLE, virq_ack=0, cpu_virq=0, cpu_vector=0,
//    busy=0, rr_ptr=0, sel=0, tmo=0, iack edge register=0. Reset mid-transaction aborts it.
//  - All outputs registered. eligible = virq_req & ~irq_mask.
//  - IDLE: if cpu_ie && |eligible: sel <= winner; cpu_vector <= VECTORS[winner];
//    cpu_virq <= 1; -> OFFER. Request-to-cpu_virq latency: 1 cycle.
//    Winner: RR=0 lowest set index; RR=1 first set index scanning rr_ptr, rr_ptr+1, .. mod N.
//  - OFFER: cpu_virq=1, sel/vector frozen (no pre-emption by higher priority).
//    - rising edge of cpu_iack: virq_ack[sel] <= 1, cpu_virq <= 0, tmo <= 0 -> ACK
//      (takes precedence even if virq_req[sel] drops in the same cycle).
//    - else if !virq_req[sel] (peripheral withdrew, e.g. data reg read): cpu_virq <= 0 -> IDLE.
//    - cpu_ie falling in OFFER does not retract; the CPU owns that decision.
//  - ACK: virq_ack[sel] held >=2 cycles (peripherals detect its rising edge).
//    tmo increments each cycle. Leave when (!virq_req[sel] && tmo>=1) or tmo==ACK_TMO:
//    virq_ack <= 0; if RR, rr_ptr <= (sel+1) mod N; -> IDLE.
//  - Re-arbitration only from IDLE; an IDLE cycle always separates two grants, so
//    back-to-back grants are >=1 cycle apart and a new offer never sees stale ack.
//  - Masking a requester after selection does not cancel the current transaction.
//  - tmo saturates; never wraps. N=1: rr_ptr stays 0.
// STRUCTURE
//  - Shared package (bk_bus_pkg): state encoding IDLE/OFFER/ACK (2 bits), VEC_W=9.
//  - One sub-module: virq_prio_pick (combinational; eligible, rr_ptr, RR -> winner idx, any).
//  - Remainder: FSM, iack edge detector, timeout counter, output registers.
// TESTING
//  1. Fixed prio: req=4'b0110, cpu_ie=1 -> cpu_virq next cycle, cpu_vector=VECTORS[1];
//     iack pulse -> virq_ack=4'b0010 for >=2 cycles until req[1] dropped, then 0.
//  2. Withdraw: req[0] up, OFFER reached, req[0] drops with no iack -> cpu_virq=0
//     next cycle, ack never asserted, busy=0.
//  3. Round-robin RR=1: req=4'b1111 held, 4 iack handshakes (each requester drops on ack,
//     re-raises after) -> grant order 0,1,2,3, then 0.
//  4. Timeout: requester ignores ack (req stuck 1), ACK_TMO=8 -> virq_ack drops after
//     exactly 8 ACK cycles; same requester re-offered after one IDLE cycle.
//  5. Simultaneous iack and req drop in OFFER -> ack still asserted 2 cycles, then IDLE.
//  6. Reset in ACK: bus_reset_n=0 one cycle -> virq_ack=0, cpu_virq=0, busy=0, rr_ptr=0
//     next cycle; masked/cpu_ie=0 pending requests never raise cpu_virq.

Source files
------------

// File: rtl/bk_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bk_bus_pkg
// Description : Shared bus constants: vector width and arbiter state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package bk_bus_pkg;

    localparam int VEC_W = 9;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_OFFER = 2'd1;
    localparam logic [1:0] c_ACK   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/virq_prio_pick.sv
`default_nettype none
// ============================================================================
// Module      : virq_prio_pick
// Description : Combinational winner select, fixed priority or rotating start.
// Revision    : 1.0 - initial release
// ============================================================================
module virq_prio_pick #(
    parameter int N  = 4,
    parameter int RR = 0,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_eligible,
    input  logic [PW-1:0] i_rr_ptr,
    output logic [PW-1:0] o_winner,
    output logic          o_any
);

    localparam logic [PW:0] c_N = (PW + 1)'(N);

    logic [PW-1:0] w_base;
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_pos;

    // Scan from the farthest slot toward the start so the nearest one wins last.
    always_comb begin
        o_winner = '0;
        o_any    = |i_eligible;
        w_base   = (RR != 0) ? i_rr_ptr : '0;
        w_sum    = '0;
        w_pos    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, w_base} + (PW + 1)'(k);
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            w_pos = w_sum[PW-1:0];
            if (i_eligible[w_pos]) begin
                o_winner = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/virq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : virq_arbiter
// Description : Shares the CPU vectored-interrupt channel among N peripherals.
// Revision    : 1.0 - initial release
// ============================================================================
module virq_arbiter
    import bk_bus_pkg::*;
#(
    parameter int                 N       = 4,
    parameter logic [N*VEC_W-1:0] VECTORS = {9'o100, 9'o070, 9'o060, 9'o274},
    parameter int                 RR      = 0,
    parameter int                 ACK_TMO = 255
) (
    input  logic             clk_bus,
    input  logic             bus_reset_n,
    input  logic [N-1:0]     virq_req,
    output logic [N-1:0]     virq_ack,
    input  logic [N-1:0]     irq_mask,
    input  logic             cpu_ie,
    output logic             cpu_virq,
    output logic [VEC_W-1:0] cpu_vector,
    input  logic             cpu_iack,
    output logic             busy
);

    localparam int            c_PW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_PW-1:0] c_LAST = c_PW'(N - 1);
    localparam logic [7:0]    c_TMO  = 8'(ACK_TMO);

    logic [1:0]       r_state;
    logic [c_PW-1:0]  r_sel;
    logic [c_PW-1:0]  r_rr_ptr;
    logic [7:0]       r_tmo;
    logic             r_iack_d;

    logic [N-1:0]     w_eligible;
    logic [c_PW-1:0]  w_winner;
    logic             w_any;
    logic             w_iack_rise;
    logic             w_req_sel;
    logic [7:0]       w_tmo_inc;

    logic [1:0]       w_state_nxt;
    logic [c_PW-1:0]  w_sel_nxt;
    logic [c_PW-1:0]  w_rr_nxt;
    logic [7:0]       w_tmo_nxt;
    logic [N-1:0]     w_ack_nxt;
    logic             w_virq_nxt;
    logic [VEC_W-1:0] w_vec_nxt;

    assign w_eligible  = virq_req & ~irq_mask;
    assign w_iack_rise = cpu_iack & ~r_iack_d;
    assign w_req_sel   = virq_req[r_sel];
    assign w_tmo_inc   = (r_tmo == 8'hFF) ? r_tmo : r_tmo + 8'd1;

    virq_prio_pick #(
        .N  (N),
        .RR (RR),
        .PW (c_PW)
    ) u_pick (
        .i_eligible (w_eligible),
        .i_rr_ptr   (r_rr_ptr),
        .o_winner   (w_winner),
        .o_any      (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_rr_nxt    = r_rr_ptr;
        w_tmo_nxt   = r_tmo;
        w_ack_nxt   = virq_ack;
        w_virq_nxt  = cpu_virq;
        w_vec_nxt   = cpu_vector;
        case (r_state)
            c_IDLE: begin
                if (cpu_ie && w_any) begin
                    w_sel_nxt   = w_winner;
                    w_vec_nxt   = VECTORS[int'(w_winner) * VEC_W +: VEC_W];
                    w_virq_nxt  = 1'b1;
                    w_state_nxt = c_OFFER;
                end
            end
            c_OFFER: begin
                // An acknowledge edge wins over a same-cycle withdrawal.
                if (w_iack_rise) begin
                    w_ack_nxt        = '0;
                    w_ack_nxt[r_sel] = 1'b1;
                    w_virq_nxt       = 1'b0;
                    w_tmo_nxt        = 8'd0;
                    w_state_nxt      = c_ACK;
                end else if (!w_req_sel) begin
                    w_virq_nxt  = 1'b0;
                    w_state_nxt = c_IDLE;
                end
            end
            c_ACK: begin
                w_tmo_nxt = w_tmo_inc;
                // r_tmo != 0 guarantees at least two ack cycles; timeout gives ACK_TMO.
                if ((!w_req_sel && r_tmo != 8'd0) || w_tmo_inc == c_TMO) begin
                    w_ack_nxt   = '0;
                    w_state_nxt = c_IDLE;
                    if (RR != 0) begin
                        w_rr_nxt = (r_sel == c_LAST) ? '0 : r_sel + 1'b1;
                    end
                end
            end
            default: begin
                w_ack_nxt   = '0;
                w_virq_nxt  = 1'b0;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_bus) begin
        if (!bus_reset_n) begin
            r_state    <= c_IDLE;
            r_sel      <= '0;
            r_rr_ptr   <= '0;
            r_tmo      <= 8'd0;
            r_iack_d   <= 1'b0;
            virq_ack   <= '0;
            cpu_virq   <= 1'b0;
            cpu_vector <= '0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_tmo      <= w_tmo_nxt;
            r_iack_d   <= cpu_iack;
            virq_ack   <= w_ack_nxt;
            cpu_virq   <= w_virq_nxt;
            cpu_vector <= w_vec_nxt;
            busy       <= (w_state_nxt != c_IDLE);
        end
    end

endmodule
`default_nettype wire
